// File: rtl/br_flow_fork_reg.sv
// Registered one-to-many flow fork.
// One push item is held in a register and offered to NumFlows pop interfaces.
// Each flow takes the item independently; a new item is accepted once every
// flow has taken (or is taking this cycle) the current one.
// pop_valid is a pure function of registered state, so no pop_ready feeds any pop_valid.
module br_flow_fork_reg #(
  parameter int NumFlows = 2,
  parameter int Width = 1,
  parameter bit EnableAssertPushValidStability = 1,
  parameter bit EnableAssertFinalNotValid = 1
) (
  input  logic                clk,
  input  logic                rst,
  output logic                push_ready,
  input  logic                push_valid,
  input  logic [Width-1:0]    push_data,
  input  logic [NumFlows-1:0] pop_ready,
  output logic [NumFlows-1:0] pop_valid,
  output logic [Width-1:0]    pop_data
);

  // Parameter legality checks at elaboration.
  if (NumFlows < 2) begin : g_bad_num_flows
    $error("br_flow_fork_reg: NumFlows must be >= 2");
  end
  if (Width < 1) begin : g_bad_width
    $error("br_flow_fork_reg: Width must be >= 1");
  end

  logic                full_q;
  logic [Width-1:0]    data_q;
  logic [NumFlows-1:0] served_q;

  logic                done;
  logic                push_hs;

  // Completion means every flow has either already taken the item or takes it now.
  always_comb begin
    done       = full_q & (&(served_q | pop_ready));
    push_ready = ~full_q | done;
    push_hs    = push_valid & push_ready;
    pop_valid  = {NumFlows{full_q}} & ~served_q;
    pop_data   = data_q;
  end

  // Occupancy and per-flow served tracking; a new push wins over plain completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q   <= 1'b0;
      served_q <= '0;
    end else if (push_hs) begin
      full_q   <= 1'b1;
      served_q <= '0;
    end else if (done) begin
      full_q   <= 1'b0;
      served_q <= '0;
    end else if (full_q) begin
      served_q <= served_q | pop_ready;
    end
  end

  // Payload register; contents are meaningless while empty, so it is not reset.
  always_ff @(posedge clk) begin
    if (push_hs) begin
      data_q <= push_data;
    end
  end

`ifndef SYNTHESIS
  // Upstream must hold a backpressured push item steady.
  if (EnableAssertPushValidStability) begin : g_push_stability
    a_push_stable: assert property (@(posedge clk) disable iff (rst)
      (push_valid && !push_ready) |=> (push_valid && $stable(push_data)));
  end

  c_push_backpressure: cover property (@(posedge clk) disable iff (rst)
    (push_valid && !push_ready));

  // Each offered pop item stays put until that flow takes it.
  for (genvar gi = 0; gi < NumFlows; gi++) begin : g_pop_checks
    a_pop_stable: assert property (@(posedge clk) disable iff (rst)
      (pop_valid[gi] && !pop_ready[gi]) |=> (pop_valid[gi] && $stable(pop_data)));
    c_pop_backpressure: cover property (@(posedge clk) disable iff (rst)
      (pop_valid[gi] && !pop_ready[gi]));
  end

  // Nothing should be left in flight when simulation ends.
  if (EnableAssertFinalNotValid) begin : g_final_not_valid
    final begin
      assert (!push_valid) else $error("br_flow_fork_reg: push_valid set at end of test");
      assert (pop_valid == '0) else $error("br_flow_fork_reg: pop_valid set at end of test");
    end
  end
`endif

endmodule

// File: tb/tb_br_flow_fork_reg.sv
// Bench for br_flow_fork_reg: a 2-flow instance for directed cases and a
// 4-flow instance for randomized backpressure, both scoreboarded per flow.
module tb_br_flow_fork_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 2-flow instance
  logic       rst2, pv2, prdy2;
  logic [7:0] pd2, popd2;
  logic [1:0] pr2, popv2;

  // 4-flow instance
  logic       rst4, pv4, prdy4;
  logic [7:0] pd4, popd4;
  logic [3:0] pr4, popv4;

  br_flow_fork_reg #(.NumFlows(2), .Width(8)) dut2 (
    .clk(clk), .rst(rst2), .push_ready(prdy2), .push_valid(pv2), .push_data(pd2),
    .pop_ready(pr2), .pop_valid(popv2), .pop_data(popd2)
  );

  br_flow_fork_reg #(.NumFlows(4), .Width(8)) dut4 (
    .clk(clk), .rst(rst4), .push_ready(prdy4), .push_valid(pv4), .push_data(pd4),
    .pop_ready(pr4), .pop_valid(popv4), .pop_data(popd4)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-flow expected items, pushed on accepted push, popped on pop handshake.
  logic [7:0] q2 [2][$];
  logic [7:0] q4 [4][$];

  // Scoreboard for the 2-flow instance, sampled mid-cycle.
  always @(negedge clk) begin
    logic exp_rdy;
    if (rst2) begin
      for (int i = 0; i < 2; i++) q2[i].delete();
    end else begin
      exp_rdy = 1'b1;
      for (int i = 0; i < 2; i++)
        if (q2[i].size() != 0 && !pr2[i]) exp_rdy = 1'b0;
      chk("rdy2", {31'd0, prdy2}, {31'd0, exp_rdy});
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("pv2[%0d]", i), {31'd0, popv2[i]}, {31'd0, q2[i].size() != 0});
        if (q2[i].size() != 0 && pr2[i]) begin
          chk($sformatf("pd2[%0d]", i), {24'd0, popd2}, {24'd0, q2[i].pop_front()});
        end
      end
      if (pv2 && exp_rdy) begin
        for (int i = 0; i < 2; i++) q2[i].push_back(pd2);
        $display("push2 data=%02h", pd2);
      end
    end
  end

  // Scoreboard for the 4-flow instance.
  always @(negedge clk) begin
    logic exp_rdy;
    if (rst4) begin
      for (int i = 0; i < 4; i++) q4[i].delete();
    end else begin
      exp_rdy = 1'b1;
      for (int i = 0; i < 4; i++)
        if (q4[i].size() != 0 && !pr4[i]) exp_rdy = 1'b0;
      chk("rdy4", {31'd0, prdy4}, {31'd0, exp_rdy});
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("pv4[%0d]", i), {31'd0, popv4[i]}, {31'd0, q4[i].size() != 0});
        if (q4[i].size() != 0 && pr4[i]) begin
          chk($sformatf("pd4[%0d]", i), {24'd0, popd4}, {24'd0, q4[i].pop_front()});
        end
      end
      if (pv4 && exp_rdy) begin
        for (int i = 0; i < 4; i++) q4[i].push_back(pd4);
      end
    end
  end

  initial begin
    int pushes;
    int cycles;
    logic acc;

    rst2 = 1'b1; pv2 = 1'b0; pd2 = 8'h00; pr2 = 2'b00;
    rst4 = 1'b1; pv4 = 1'b0; pd4 = 8'h00; pr4 = 4'b0000;
    tick(); tick();
    rst2 = 1'b0; rst4 = 1'b0;
    chk("reset_pop_valid", {30'd0, popv2}, 32'd0);
    chk("reset_push_ready", {31'd0, prdy2}, 32'd1);

    // Single push then back-to-back streaming with all flows ready.
    pv2 = 1'b1; pd2 = 8'hA5; pr2 = 2'b11;
    tick();
    chk("t1_pop_valid", {30'd0, popv2}, 32'd3);
    chk("t1_pop_data", {24'd0, popd2}, 32'hA5);
    chk("t1_push_ready", {31'd0, prdy2}, 32'd1);
    for (int k = 1; k <= 4; k++) begin
      pd2 = 8'(k);
      tick();
      chk("stream_pop_valid", {30'd0, popv2}, 32'd3);
      chk("stream_pop_data", {24'd0, popd2}, k);
    end
    pv2 = 1'b0;
    tick();
    chk("stream_drained", {30'd0, popv2}, 32'd0);

    // Flows take the item on different cycles.
    pv2 = 1'b1; pd2 = 8'h3C; pr2 = 2'b00;
    tick();
    pv2 = 1'b0; pr2 = 2'b01;
    #1;
    chk("t2_c1_pop_valid", {30'd0, popv2}, 32'd3);
    chk("t2_c1_push_ready", {31'd0, prdy2}, 32'd0);
    tick();
    pr2 = 2'b10;
    #1;
    chk("t2_c2_pop_valid", {30'd0, popv2}, 32'd2);
    chk("t2_c2_push_ready", {31'd0, prdy2}, 32'd1);
    tick();
    pr2 = 2'b00;
    chk("t2_c3_pop_valid", {30'd0, popv2}, 32'd0);

    // Completion on the last flow coincides with the next push.
    pv2 = 1'b1; pd2 = 8'h55;
    tick();
    pv2 = 1'b0; pr2 = 2'b01;
    tick();
    pr2 = 2'b10; pv2 = 1'b1; pd2 = 8'h77;
    #1;
    chk("t3_push_ready", {31'd0, prdy2}, 32'd1);
    tick();
    pv2 = 1'b0; pr2 = 2'b00;
    chk("t3_pop_valid", {30'd0, popv2}, 32'd3);
    chk("t3_pop_data", {24'd0, popd2}, 32'h77);
    pr2 = 2'b11;
    tick();

    // Ready with nothing held changes nothing.
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_pop_valid", {30'd0, popv2}, 32'd0);
      chk("t4_push_ready", {31'd0, prdy2}, 32'd1);
    end

    // Reset while partially served, then a clean delivery.
    pr2 = 2'b00; pv2 = 1'b1; pd2 = 8'h99;
    tick();
    pv2 = 1'b0; pr2 = 2'b01;
    tick();
    pr2 = 2'b00; rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
    chk("t5_pop_valid", {30'd0, popv2}, 32'd0);
    chk("t5_push_ready", {31'd0, prdy2}, 32'd1);
    pv2 = 1'b1; pd2 = 8'h11; pr2 = 2'b11;
    tick();
    pv2 = 1'b0;
    chk("t5_pop_valid_new", {30'd0, popv2}, 32'd3);
    chk("t5_pop_data_new", {24'd0, popd2}, 32'h11);
    tick();
    chk("t5_drained", {30'd0, popv2}, 32'd0);

    // Randomized backpressure on four flows.
    pushes = 0;
    cycles = 0;
    while (pushes < 1000 && cycles < 20000) begin
      pr4 = 4'($urandom);
      if (!pv4 && ($urandom_range(0, 3) != 0)) begin
        pv4 = 1'b1;
        pd4 = 8'($urandom);
      end
      #2;
      acc = pv4 && prdy4;
      tick();
      cycles++;
      if (acc) begin
        pushes++;
        pv4 = 1'b0;
      end
    end
    chk("rand_push_count", pushes, 32'd1000);
    pv4 = 1'b0; pr4 = 4'b1111;
    for (int k = 0; k < 4; k++) tick();
    for (int i = 0; i < 4; i++) chk("rand_drain", q4[i].size(), 32'd0);
    chk("rand_final_pop_valid", {28'd0, popv4}, 32'd0);
    pr2 = 2'b00; pr4 = 4'b0000;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
